// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit cpu subsystem: loader state encoding and frame constants.
package cpu_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLen,
    StData,
    StCsum,
    StRun,
    StErr
  } ld_state_e;

  // A LEN byte of zero encodes a full 256-byte program.
  localparam bit LEN_ZERO_MEANS_256 = 1'b1;

  localparam logic [7:0] DEFAULT_BASE_ADDR = 8'h00;

endpackage

// File: rtl/prog_loader_if.sv
// Host byte stream, ram write port and cpu control signals of the program loader.
interface prog_loader_if;
  logic       load_start;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic [7:0] ram_addr;
  logic [7:0] ram_data;
  logic       ram_wren;
  logic       cpu_halt;
  logic       cpu_run;
  logic       busy;
  logic       done;
  logic       err;

  // Host side: drives the stream and observes the loader.
  modport master (
    output load_start, in_valid, in_data,
    input  in_ready, ram_addr, ram_data, ram_wren, cpu_halt, cpu_run, busy, done, err
  );

  // Loader side.
  modport slave (
    input  load_start, in_valid, in_data,
    output in_ready, ram_addr, ram_data, ram_wren, cpu_halt, cpu_run, busy, done, err
  );
endinterface

// File: rtl/byte_stream_timer.sv
// Idle-gap timer for byte streams: expired flags the TIMEOUT-th consecutive enabled cycle
// without a clear, so the caller can act on that cycle unless a byte arrives.
module byte_stream_timer #(
  parameter int unsigned TIMEOUT = 1023,
  parameter int unsigned TW      = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam logic [TW-1:0] LastCount = TW'(TIMEOUT - 1);

  logic [TW-1:0] cnt_q;

  assign expired_o = enable_i && (cnt_q == LastCount);

  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      cnt_q <= '0;
    end else if (enable_i && !expired_o) begin
      cnt_q <= cnt_q + TW'(1);
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Receives a LEN/DATA/CSUM framed program, writes it to ram with the cpu halted and
// releases the cpu with a one-cycle run pulse when the checksum matches.
module prog_loader
  import cpu_pkg::*;
#(
  parameter logic [7:0]  BASE_ADDR = DEFAULT_BASE_ADDR,
  parameter int unsigned TIMEOUT   = 1023,
  parameter int unsigned TW        = 10
) (
  input logic         clk,
  input logic         rst,
  prog_loader_if.slave bus
);

  ld_state_e  state_q;
  logic [8:0] count_q;
  logic [7:0] idx_q;
  logic [7:0] sum_q;
  logic [7:0] ram_addr_q, ram_data_q;
  logic       ram_wren_q, cpu_halt_q, cpu_run_q, busy_q, done_q, err_q;

  logic       in_ready, accept, start_take, expired;
  logic [8:0] idx_next;
  logic [8:0] len_count;

  assign in_ready   = (state_q == StLen) || (state_q == StData) || (state_q == StCsum);
  assign accept     = bus.in_valid && in_ready;
  assign start_take = (state_q == StIdle) && bus.load_start;
  assign idx_next   = {1'b0, idx_q} + 9'd1;
  assign len_count  = (LEN_ZERO_MEANS_256 && (bus.in_data == 8'h00)) ? 9'd256
                                                                       : {1'b0, bus.in_data};

  byte_stream_timer #(
    .TIMEOUT (TIMEOUT),
    .TW      (TW)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (start_take || accept),
    .enable_i  (in_ready),
    .expired_o (expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      count_q    <= '0;
      idx_q      <= '0;
      sum_q      <= '0;
      ram_addr_q <= '0;
      ram_data_q <= '0;
      ram_wren_q <= 1'b0;
      cpu_halt_q <= 1'b0;
      cpu_run_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      ram_wren_q <= 1'b0;
      cpu_run_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.load_start) begin
            state_q    <= StLen;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            cpu_halt_q <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        StLen: begin
          if (accept) begin
            count_q <= len_count;
            idx_q   <= '0;
            sum_q   <= '0;
            state_q <= StData;
          end else if (expired) begin
            state_q <= StErr;
            err_q   <= 1'b1;
          end
        end
        StData: begin
          if (accept) begin
            ram_addr_q <= BASE_ADDR + idx_q;
            ram_data_q <= bus.in_data;
            ram_wren_q <= 1'b1;
            sum_q      <= sum_q + bus.in_data;
            idx_q      <= idx_next[7:0];
            if (idx_next == count_q) state_q <= StCsum;
          end else if (expired) begin
            state_q <= StErr;
            err_q   <= 1'b1;
          end
        end
        StCsum: begin
          if (accept) begin
            if (bus.in_data == sum_q) begin
              state_q    <= StRun;
              cpu_run_q  <= 1'b1;
              cpu_halt_q <= 1'b0;
              done_q     <= 1'b1;
            end else begin
              state_q <= StErr;
              err_q   <= 1'b1;
            end
          end else if (expired) begin
            state_q <= StErr;
            err_q   <= 1'b1;
          end
        end
        StRun, StErr: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.in_ready = in_ready;
  assign bus.ram_addr = ram_addr_q;
  assign bus.ram_data = ram_data_q;
  assign bus.ram_wren = ram_wren_q;
  assign bus.cpu_halt = cpu_halt_q;
  assign bus.cpu_run  = cpu_run_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench: two loaders share one byte stream, u0 with defaults and u1 with
// BASE_ADDR = FE and TIMEOUT = 8, so address wrap and timeout are covered alongside.
module tb_prog_loader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load_start = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int run0 = 0;
  int run1 = 0;
  logic [15:0] w0[$];
  logic [15:0] w1[$];
  int t0[$];

  prog_loader_if b0 ();
  prog_loader_if b1 ();

  assign b0.load_start = load_start;
  assign b0.in_valid   = in_valid;
  assign b0.in_data    = in_data;
  assign b1.load_start = load_start;
  assign b1.in_valid   = in_valid;
  assign b1.in_data    = in_data;

  prog_loader u0 (
    .clk (clk),
    .rst (rst),
    .bus (b0.slave)
  );

  prog_loader #(
    .BASE_ADDR (8'hFE),
    .TIMEOUT   (8),
    .TW        (4)
  ) u1 (
    .clk (clk),
    .rst (rst),
    .bus (b1.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (b0.ram_wren) begin
      w0.push_back({b0.ram_addr, b0.ram_data});
      t0.push_back(cyc);
    end
    if (b1.ram_wren) w1.push_back({b1.ram_addr, b1.ram_data});
    if (b0.cpu_run) run0 <= run0 + 1;
    if (b1.cpu_run) run1 <= run1 + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed no end of test, expected $finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load();
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    chk("start_halt", b0.cpu_halt, 1);
    chk("start_busy", b0.busy, 1);
  endtask

  task automatic send(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    chk("send_ready", b0.in_ready, 1);
    step();
    in_valid = 1'b0;
  endtask

  int base0, base1, r0, r1, bad;

  initial begin
    // Reset
    step();
    step();
    chk("rst_ready", b0.in_ready, 0);
    chk("rst_wren", b0.ram_wren, 0);
    chk("rst_halt", b0.cpu_halt, 0);
    chk("rst_flags", {b0.busy, b0.done, b0.err, b0.cpu_run}, 0);
    chk("rst_addr_data", {b0.ram_addr, b0.ram_data}, 0);
    rst = 1'b0;
    step();

    // Good frame 03 0A 0B 0C 21
    base0 = w0.size(); base1 = w1.size(); r0 = run0; r1 = run1;
    start_load();
    send(8'h03); send(8'h0A); send(8'h0B); send(8'h0C); send(8'h21);
    chk("ok_run", b0.cpu_run, 1);
    chk("ok_done", b0.done, 1);
    chk("ok_halt", b0.cpu_halt, 0);
    chk("ok_u1_run", b1.cpu_run, 1);
    step();
    chk("ok_idle", {b0.busy, b0.cpu_run, b0.done, b0.err, b0.cpu_halt}, 5'b00100);
    chk("ok_nwr", w0.size() - base0, 3);
    chk("ok_w0", w0[base0], 16'h000A);
    chk("ok_w1", w0[base0+1], 16'h010B);
    chk("ok_w2", w0[base0+2], 16'h020C);
    chk("ok_b2b", {t0[base0+1] - t0[base0], t0[base0+2] - t0[base0+1]}, {32'd1, 32'd1} >> 0);
    chk("ok_runs", run0 - r0, 1);
    chk("wrap_nwr", w1.size() - base1, 3);
    chk("wrap_w0", w1[base1], 16'hFE0A);
    chk("wrap_w1", w1[base1+1], 16'hFF0B);
    chk("wrap_w2", w1[base1+2], 16'h000C);
    chk("wrap_runs", run1 - r1, 1);

    // Bad checksum 22
    base0 = w0.size(); r0 = run0;
    start_load();
    chk("bad_cleared", {b0.done, b0.err}, 0);
    send(8'h03); send(8'h0A); send(8'h0B); send(8'h0C); send(8'h22);
    chk("bad_err", b0.err, 1);
    chk("bad_done", b0.done, 0);
    chk("bad_halt", b0.cpu_halt, 1);
    chk("bad_run", b0.cpu_run, 0);
    step();
    chk("bad_idle", {b0.busy, b0.cpu_halt, b0.err}, 3'b011);
    chk("bad_nwr", w0.size() - base0, 3);
    chk("bad_runs", run0 - r0, 0);

    // LEN 00 -> 256 bytes of 01, CSUM 00
    base0 = w0.size(); base1 = w1.size(); r0 = run0; r1 = run1;
    start_load();
    send(8'h00);
    for (int i = 0; i < 256; i++) send(8'h01);
    send(8'h00);
    chk("l256_run", b0.cpu_run, 1);
    step();
    chk("l256_nwr", w0.size() - base0, 256);
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      if (w0[base0+i] !== {8'(i), 8'h01}) bad++;
    end
    chk("l256_addrs", bad, 0);
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      if (w1[base1+i] !== {8'(i + 254), 8'h01}) bad++;
    end
    chk("l256_u1_addrs", bad, 0);
    chk("l256_runs", {run0 - r0, run1 - r1}, {32'd1, 32'd1} >> 0);
    chk("l256_done", {b0.done, b0.err, b0.cpu_halt}, 3'b100);

    // Timeout on u1: LEN 02, one byte, then idle
    base1 = w1.size();
    start_load();
    send(8'h02);
    send(8'hAA);
    for (int k = 1; k <= 7; k++) begin
      step();
      chk("to_wait_err", b1.err, 0);
    end
    step();
    chk("to_err", b1.err, 1);
    chk("to_halt", {b1.cpu_halt, b1.busy, b1.done}, 3'b110);
    step();
    step();
    chk("to_idle_busy", b1.busy, 0);
    chk("to_nwr", w1.size() - base1, 1);

    // Reset, then an accept on the 8th idle cycle avoids the timeout
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst2_state", {b0.in_ready, b0.busy, b0.ram_wren, b0.cpu_halt, b0.done, b0.err}, 0);
    start_load();
    send(8'h02);
    send(8'h05);
    for (int k = 1; k <= 7; k++) step();
    in_valid = 1'b1;
    in_data  = 8'h07;
    step();
    in_valid = 1'b0;
    chk("edge_err", b1.err, 0);
    chk("edge_wr", {b1.ram_wren, b1.ram_addr, b1.ram_data}, {1'b1, 8'hFF, 8'h07});
    send(8'h0C);
    chk("edge_run", {b1.cpu_run, b1.done, b1.err}, 3'b110);
    step();

    // Reset mid-DATA; load_start while busy is ignored
    base0 = w0.size();
    start_load();
    send(8'h03); send(8'h11); send(8'h22);
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    chk("busy_start_ign", {b0.busy, b0.in_ready, b0.ram_wren, b0.cpu_halt}, 4'b1101);
    rst      = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h33;
    step();
    rst = 1'b0;
    chk("mid_rst", {b0.ram_wren, b0.in_ready, b0.busy, b0.cpu_halt}, 0);
    for (int k = 0; k < 3; k++) step();
    chk("unready_busy", b0.busy, 0);
    in_valid = 1'b0;
    step();
    chk("mid_nwr", w0.size() - base0, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
